// File: rtl/psum_collector.sv
// Column-bottom partial-sum collector: accumulates K-tile psum beats per output,
// requantizes each finished sum to 16 bits and queues it in a small result FIFO.
module psum_collector #(
    parameter int ACC_WIDTH = 40,
    parameter int DEPTH     = 4
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               start,
    input  logic [7:0]         num_tiles,
    input  logic [7:0]         num_outputs,
    input  logic [4:0]         shift_amt,
    input  logic               relu_en,
    input  logic               psum_valid,
    input  logic signed [31:0] psum_in,
    output logic               psum_ready,
    output logic               out_valid,
    output logic signed [15:0] out_data,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic               acc_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH + 1)'(32767);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = -SAT_MAX - 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t                       state;
    logic [7:0]                   tiles_cfg;
    logic [7:0]                   outs_cfg;
    logic [4:0]                   shift_cfg;
    logic                         relu_cfg;
    logic [7:0]                   tile_cnt;
    logic [7:0]                   out_cnt;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  psum_ext;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic                         ovf;
    logic                         accept;
    logic                         last_beat;
    logic                         push;
    logic                         pop;
    logic [AW:0]                  count;
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic signed [15:0]           mem [DEPTH];

    function automatic logic signed [15:0] sat16(input logic signed [ACC_WIDTH:0] r);
        if (r > SAT_MAX)
            return 16'sh7fff;
        else if (r < SAT_MIN)
            return 16'sh8000;
        else
            return $signed(r[15:0]);
    endfunction

    // Round-half-up before the arithmetic shift; one guard bit keeps the add exact.
    function automatic logic signed [15:0] requant(input logic signed [ACC_WIDTH-1:0] s,
                                                   input logic [4:0] sh,
                                                   input logic relu);
        logic signed [ACC_WIDTH:0] ext;
        logic signed [ACC_WIDTH:0] rnd;
        logic signed [ACC_WIDTH:0] r;
        ext = {s[ACC_WIDTH-1], s};
        rnd = (sh == 5'd0) ? '0 : ((ACC_WIDTH + 1)'(1) << (sh - 5'd1));
        r = (ext + rnd) >>> sh;
        if (relu && r[ACC_WIDTH])
            r = '0;
        return sat16(r);
    endfunction

    always_comb begin
        psum_ext   = ACC_WIDTH'(psum_in);
        sum        = acc + psum_ext;
        ovf        = (acc[ACC_WIDTH-1] == psum_ext[ACC_WIDTH-1]) &&
                     (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
        psum_ready = (state == ACCUM) && (count < FULL);
        accept     = psum_valid && psum_ready;
        last_beat  = (tile_cnt == tiles_cfg - 8'd1);
        push       = accept && last_beat;
        out_valid  = (count != '0);
        pop        = out_valid && out_ready;
        out_data   = out_valid ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            acc_ovf  <= 1'b0;
            tile_cnt <= '0;
            out_cnt  <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            done <= 1'b0;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        acc_ovf  <= 1'b0;
                        tile_cnt <= '0;
                        out_cnt  <= '0;
                        state    <= (num_outputs == 8'd0) ? DRAIN : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (ovf)
                            acc_ovf <= 1'b1;
                        if (last_beat) begin
                            tile_cnt <= '0;
                            out_cnt  <= out_cnt + 8'd1;
                            if (out_cnt + 8'd1 == outs_cfg)
                                state <= DRAIN;
                        end else begin
                            tile_cnt <= tile_cnt + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    // Finish on the edge that leaves the FIFO empty.
                    if (count == '0 || (count == (AW + 1)'(1) && pop)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; start re-initialises them for each job.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            tiles_cfg <= (num_tiles == 8'd0) ? 8'd1 : num_tiles;
            outs_cfg  <= num_outputs;
            shift_cfg <= shift_amt;
            relu_cfg  <= relu_en;
            acc       <= '0;
        end else if (accept) begin
            acc <= last_beat ? '0 : sum;
        end
        if (push)
            mem[wr_ptr] <= requant(sum, shift_cfg, relu_cfg);
    end

endmodule

// File: tb/tb_psum_collector.sv
// Bench for psum_collector: transaction-level reference model checked every cycle,
// plus directed jobs with hand-computed expectations.
module tb_psum_collector;

    localparam int DEPTH = 4;
    localparam longint SPAN = longint'(1) << 40;
    localparam longint AMAX = (longint'(1) << 39) - 1;
    localparam longint AMIN = -(longint'(1) << 39);

    logic clk = 1'b0;
    logic RST = 1'b1;
    logic start = 1'b0;
    logic [7:0] num_tiles = '0;
    logic [7:0] num_outputs = '0;
    logic [4:0] shift_amt = '0;
    logic relu_en = 1'b0;
    logic psum_valid = 1'b0;
    logic signed [31:0] psum_in = '0;
    logic out_ready = 1'b0;
    logic psum_ready, out_valid, busy, done, acc_ovf;
    logic signed [15:0] out_data;
    logic psum_ready_32, out_valid_32, busy_32, done_32, acc_ovf_32;
    logic signed [15:0] out_data_32;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    psum_collector #(.ACC_WIDTH(40), .DEPTH(DEPTH)) dut (
        .clk(clk), .RST(RST), .start(start), .num_tiles(num_tiles),
        .num_outputs(num_outputs), .shift_amt(shift_amt), .relu_en(relu_en),
        .psum_valid(psum_valid), .psum_in(psum_in), .psum_ready(psum_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done), .acc_ovf(acc_ovf)
    );

    psum_collector #(.ACC_WIDTH(32), .DEPTH(DEPTH)) dut32 (
        .clk(clk), .RST(RST), .start(start), .num_tiles(num_tiles),
        .num_outputs(num_outputs), .shift_amt(shift_amt), .relu_en(relu_en),
        .psum_valid(psum_valid), .psum_in(psum_in), .psum_ready(psum_ready_32),
        .out_valid(out_valid_32), .out_data(out_data_32), .out_ready(out_ready),
        .busy(busy_32), .done(done_32), .acc_ovf(acc_ovf_32)
    );

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic longint mq(input longint s, input int sh, input bit relu);
        longint r;
        r = s + ((sh > 0) ? (longint'(1) << (sh - 1)) : longint'(0));
        r = r >>> sh;
        if (relu && r < 0) r = 0;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    // Reference model: job phase 0=idle, 1=collecting, 2=draining.
    int     m_phase = 0;
    longint m_q[$];
    longint m_acc = 0;
    int     m_tiles = 1, m_outs = 0, m_sh = 0, m_tcnt = 0, m_ocnt = 0;
    bit     m_relu = 0, m_busy = 0, m_done = 0, m_ovf = 0;

    always @(posedge clk or posedge RST) begin
        if (RST) begin
            m_phase = 0; m_q.delete(); m_busy = 0; m_done = 0; m_ovf = 0;
        end else begin
            bit rdy, pop, beat;
            longint s;
            rdy  = (m_phase == 1) && (m_q.size() < DEPTH);
            pop  = (m_q.size() > 0) && out_ready;
            beat = rdy && psum_valid;
            m_done = 0;
            if (pop) void'(m_q.pop_front());
            if (m_phase == 0) begin
                if (start) begin
                    m_tiles = (num_tiles == 0) ? 1 : int'(num_tiles);
                    m_outs = num_outputs; m_sh = shift_amt; m_relu = relu_en;
                    m_acc = 0; m_tcnt = 0; m_ocnt = 0; m_ovf = 0; m_busy = 1;
                    m_phase = (num_outputs == 0) ? 2 : 1;
                end
            end else if (m_phase == 1) begin
                if (beat) begin
                    s = m_acc + longint'(psum_in);
                    if (s > AMAX) begin s = s - SPAN; m_ovf = 1; end
                    if (s < AMIN) begin s = s + SPAN; m_ovf = 1; end
                    m_tcnt++;
                    if (m_tcnt == m_tiles) begin
                        m_q.push_back(mq(s, m_sh, m_relu));
                        m_acc = 0; m_tcnt = 0; m_ocnt++;
                        if (m_ocnt == m_outs) m_phase = 2;
                    end else begin
                        m_acc = s;
                    end
                end
            end else begin
                if (m_q.size() == 0) begin
                    m_done = 1; m_busy = 0; m_phase = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit exp_rdy;
        exp_rdy = (m_phase == 1) && (m_q.size() < DEPTH);
        check("psum_ready", psum_ready, exp_rdy);
        check("out_valid", out_valid, m_q.size() > 0);
        if (m_q.size() > 0) check("out_data", out_data, m_q[0]);
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("acc_ovf", acc_ovf, m_ovf);
        check("psum_ready_32", psum_ready_32, exp_rdy);
        check("out_valid_32", out_valid_32, m_q.size() > 0);
        check("busy_32", busy_32, m_busy);
        check("done_32", done_32, m_done);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int t, input int o, input int sh, input bit relu);
        num_tiles = 8'(t); num_outputs = 8'(o); shift_amt = 5'(sh); relu_en = relu;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic beat(input logic signed [31:0] v);
        psum_valid = 1'b1;
        psum_in = v;
        step();
        psum_valid = 1'b0;
    endtask

    task automatic drain_job(input string nm);
        bit seen;
        seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (done) seen = 1;
        end
        out_ready = 1'b0;
        check(nm, seen, 1);
        check({nm, "_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        longint got[$];
        bit took, seen;

        step(); step();
        check("rst_psum_ready", psum_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_acc_ovf", acc_ovf, 0);
        RST = 1'b0;
        step();

        // 100 - 30 + 7 = 77, visible right after the third beat's edge
        start_job(3, 1, 0, 0);
        check("t1_ready_after_start", psum_ready, 1);
        check("t1_busy", busy, 1);
        beat(100); beat(-30);
        check("t1_not_yet_valid", out_valid, 0);
        beat(7);
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 77);
        step();
        check("t1_data_stable", out_data, 77);
        check("t1_no_done_before_pop", done, 0);
        drain_job("t1_done");
        step();
        check("t1_done_one_cycle", done, 0);

        // (40+8)>>>4 = 3
        start_job(2, 1, 4, 0);
        beat(40); beat(0);
        check("t2_round", out_data, 3);
        drain_job("t2_done");
        // (-40+8)>>>4 = -2, ReLU -> 0
        start_job(2, 1, 4, 1);
        beat(-40); beat(0);
        check("t2_relu_valid", out_valid, 1);
        check("t2_relu", out_data, 0);
        drain_job("t2r_done");

        // Saturation; the 32-bit instance wraps instead
        start_job(2, 1, 0, 0);
        beat(32'sh7fff0000); beat(32'sh7fff0000);
        check("t3_sat_hi", out_data, 32767);
        check("t3_no_ovf", acc_ovf, 0);
        check("t3_sat_hi_32", out_data_32, -32768);
        drain_job("t3_done");
        start_job(2, 1, 0, 0);
        beat(32'sh80000000); beat(-1);
        check("t3_sat_lo", out_data, -32768);
        check("t3_sat_lo_32", out_data_32, 32767);
        drain_job("t3b_done");

        // Accumulator overflow at 32 bits is sticky until the next start
        start_job(2, 1, 0, 0);
        check("t4_ovf_cleared_32", acc_ovf_32, 0);
        beat(32'sh7fffffff); beat(1);
        check("t4_ovf_32", acc_ovf_32, 1);
        check("t4_ovf_40", acc_ovf, 0);
        check("t4_data_40", out_data, 32767);
        check("t4_data_32", out_data_32, -32768);
        drain_job("t4_done");
        step();
        check("t4_ovf_sticky", acc_ovf_32, 1);

        // Backpressure with a 4-entry FIFO
        start_job(1, 6, 0, 0);
        check("t5_ovf_cleared", acc_ovf_32, 0);
        for (int i = 0; i < 4; i++) beat(32'(10 * (i + 1)));
        check("t5_full", psum_ready, 0);
        check("t5_head", out_data, 10);
        psum_valid = 1'b1; psum_in = 50;
        step(); step();
        check("t5_hold", psum_ready, 0);
        got.push_back(longint'(out_data));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t5_one_free", psum_ready, 1);
        check("t5_head2", out_data, 20);
        step();
        check("t5_refull", psum_ready, 0);
        psum_in = 60;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (out_valid && out_ready) got.push_back(longint'(out_data));
            took = psum_valid && psum_ready;
            step();
            if (took) psum_valid = 1'b0;
            if (done) seen = 1;
        end
        out_ready = 1'b0;
        psum_valid = 1'b0;
        check("t5_done", seen, 1);
        check("t5_count", got.size(), 6);
        for (int i = 0; i < 6; i++)
            check("t5_order", (i < got.size()) ? got[i] : -1, 10 * (i + 1));

        // num_outputs = 0: done one cycle after the start edge
        start_job(1, 0, 0, 0);
        check("t6_busy", busy, 1);
        check("t6_no_done", done, 0);
        step();
        check("t6_done", done, 1);
        check("t6_busy_low", busy, 0);
        step();
        check("t6_done_low", done, 0);

        // Reset mid-job with two results queued
        start_job(1, 4, 0, 0);
        beat(5); beat(6);
        check("t7_two_queued", out_valid, 1);
        RST = 1'b1;
        step();
        check("t7_rst_valid", out_valid, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_ready", psum_ready, 0);
        RST = 1'b0;
        step();
        // (9+4+2)>>>2 = 3
        start_job(2, 1, 2, 0);
        beat(9); beat(4);
        check("t7_clean_data", out_data, 3);
        drain_job("t7_done");
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/psum_collector.md
# psum_collector

Bottom-of-column drain for the BitFusion systolic array. Accepts the signed 32-bit partial sums leaving the last fusion unit of a column and accumulates a programmed number of beats (K-tiles) per output element. Each finished sum is rounded, right-shifted, optionally ReLU'd and saturated to 16 bits, then buffered in a small FIFO that the output-buffer writer drains through a valid/ready handshake.

## Interface
- ACC_WIDTH, 40: signed accumulator width; must be ≥ 32.
- DEPTH, 4: result FIFO depth in entries; power of two, ≥ 2.
- Clocking/reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that launches a job; ignored unless the FSM is in IDLE.
- num_tiles  in  8  psum beats per output element; 0 is treated as 1; sampled on start.
- num_outputs  in  8  output elements per job; sampled on start.
- shift_amt  in  5  arithmetic right-shift used for requantization; sampled on start.
- relu_en  in  1  clamp negative results to 0; sampled on start.
- psum_valid  in  1  upstream psum beat is valid.
- psum_in  in  32  signed psum from the fusion unit column.
- psum_ready  out  1  beat is accepted on an edge where psum_valid && psum_ready.
- out_valid  out  1  FIFO is not empty.
- out_data  out  16  signed result at the FIFO head.
- out_ready  in  1  pop occurs on an edge where out_valid && out_ready.
- busy  out  1  high from the edge that accepts start until the edge that raises done.
- done  out  1  one-cycle pulse marking job completion.
- acc_ovf  out  1  sticky accumulator-overflow flag; cleared by start or RST.

## Operation
- FSM states: IDLE, ACCUM, DRAIN.
- IDLE → ACCUM on start when num_outputs ≠ 0. On that edge, latch the config, clear acc, tile_cnt, out_cnt and acc_ovf, and set busy.
- IDLE → DRAIN on start when num_outputs = 0.
- ACCUM: psum_ready = (fifo_count < DEPTH). A pop in the same cycle does not free space; there is no pass-through.
- On each accepted beat, sum = acc + sext(psum_in) at ACC_WIDTH bits, with two's-complement wrap. Signed overflow of this add sets acc_ovf.
- Beat with tile_cnt < eff_tiles−1: acc ← sum, tile_cnt increments.
- Last beat (tile_cnt = eff_tiles−1):
  - Push requant(sum) into the FIFO.
  - Clear acc and tile_cnt; out_cnt increments.
  - If out_cnt reaches num_outputs, go to DRAIN.
- requant(s), evaluated in this order:
  - r = (s + (shift_amt>0 ? 2^(shift_amt−1) : 0)) >>> shift_amt, computed at ACC_WIDTH+1 bits.
  - If relu_en and r < 0, then r = 0.
  - Saturate r to [−32768, 32767].
- DRAIN: psum_ready = 0. When fifo_count = 0, pulse done for one cycle, clear busy and return to IDLE.
- FIFO pops are independent of FSM state, including pops while in ACCUM.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and order is preserved.
- RST at any time empties the FIFO and clears all counters and flags. Any in-flight job is discarded.

## Timing
- Reset values: psum_ready=0, out_valid=0, out_data=0, busy=0, done=0, acc_ovf=0. State = IDLE.
- start edge to psum_ready high: 1 cycle, i.e. from the next cycle, if the FIFO has space.
- Last-beat accept edge to out_valid: out_valid rises after the same edge when the FIFO was empty. Latency is 1 cycle.
- out_data is registered at the FIFO head and is stable while out_valid && !out_ready.
- After the edge that makes the FIFO empty in DRAIN, done is high for exactly one cycle; busy falls on that same edge.
- num_outputs = 0: start at edge N gives done high in cycle N+1.
- Full throughput is one psum beat per cycle while the FIFO is not full.

## Test plan
- num_tiles=3, num_outputs=1, shift=0, relu off; beats 100, −30, 7 on consecutive cycles → out_data=77 exactly one cycle after the third beat; done pulses after it is popped.
- num_tiles=2, shift=4; beats 40, 0 → (40+8)>>>4 = 3. With relu_en=1 and beats −40, 0 → 0 (rounding gives −2 before ReLU).
- Saturation: num_tiles=2, shift=0; beats 0x7FFF0000, 0x7FFF0000 → 32767 with acc_ovf=0. Beats 0x80000000 and −1 → −32768.
- Backpressure: DEPTH=4, num_tiles=1, num_outputs=6, out_ready=0 → psum_ready drops after 4 pushes. Raise out_ready for 1 cycle → one pop, then exactly one more beat accepted the cycle after. All 6 results come out in order.
- ACC_WIDTH=32, num_tiles=2; beats 0x7FFFFFFF, 1 → acc_ovf=1 and it stays set until the next start.
- Assert RST mid-ACCUM with 2 results in the FIFO → next cycle out_valid=0, busy=0, psum_ready=0. A new start runs a clean job with correct values.
